// File: rtl/piezo_pkg.sv
// piezo_pkg: note half-periods, source/state encodings and lookup helpers
// shared by the piezo sound scheduler and its tone generator.
package piezo_pkg;
   localparam logic [10:0] HP_DO = 11'd1911;
   localparam logic [10:0] HP_RE = 11'd1703;
   localparam logic [10:0] HP_MI = 11'd1517;
   localparam logic [10:0] HP_SO = 11'd1276;
   typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_CLICK = 2'd1, SRC_RESULT = 2'd2, SRC_MELODY = 2'd3} src_t;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_NOTE = 2'd1, ST_GAP = 2'd2} state_t;
   // Arbitration rank: result beats melody beats click; the source code order differs.
   function automatic logic [1:0] src_prio(input src_t s);
      return s == SRC_RESULT ? 2'd3 : s == SRC_MELODY ? 2'd2 : s == SRC_CLICK ? 2'd1 : 2'd0;
   endfunction
   function automatic logic [10:0] note_hp(input src_t s, input logic [1:0] idx, input logic eq);
      return s == SRC_CLICK ? HP_SO : s == SRC_RESULT ? (eq ? HP_DO : HP_RE) :
             idx == 2'd0 ? HP_DO : idx == 2'd1 ? HP_RE : idx == 2'd2 ? HP_MI : HP_SO;
   endfunction
endpackage

// File: rtl/piezo_tone_gen.sv
// piezo_tone_gen: square wave toggling every half_period cycles; en=0 holds
// the output low and clears the counter so each note starts low and in phase.
module piezo_tone_gen (
   input  logic        clk_1mhz,
   input  logic        rst_n,
   input  logic        en,
   input  logic [10:0] half_period,
   output logic        piezo
);
   logic [10:0] cnt_q, cnt_d;
   logic        piezo_q, piezo_d, wrap;
   assign wrap = cnt_q == half_period - 11'd1;
   always_comb begin
      cnt_d   = !en ? '0 : wrap ? '0 : cnt_q + 11'd1;
      piezo_d = !en ? 1'b0 : wrap ? ~piezo_q : piezo_q;
   end
   always_ff @(posedge clk_1mhz or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         piezo_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         piezo_q <= piezo_d;
      end
   end
   assign piezo = piezo_q;
endmodule

// File: rtl/piezo_sound_scheduler.sv
// piezo_sound_scheduler: arbitrates one-shot sound requests by fixed priority
// and steps the chosen note table with ms-timed notes and gaps.
module piezo_sound_scheduler
   import piezo_pkg::*;
#(
   parameter int TICK_DIV    = 1000,
   parameter int CLICK_MS    = 50,
   parameter int RESULT_MS   = 2000,
   parameter int MEL_NOTE_MS = 200,
   parameter int MEL_GAP_MS  = 20
) (
   input  logic       clk_1mhz,
   input  logic       rst_n,
   input  logic       req_click,
   input  logic       req_result,
   input  logic       result_equal,
   input  logic       req_melody,
   output logic       busy,
   output logic [1:0] active_src,
   output logic       done,
   output logic       req_drop,
   output logic       piezo
);
   state_t      state_q, state_d;
   src_t        src_q, src_d, win;
   logic [1:0]  idx_q, idx_d;
   logic        eq_q, eq_d, done_q, done_d, drop_q, drop_d;
   logic [9:0]  tick_q, tick_d;
   logic [10:0] ms_q, ms_d, len;
   logic        accept, multi, tick, expire, last, note_start, clear;
   assign win    = req_result ? SRC_RESULT : req_melody ? SRC_MELODY : req_click ? SRC_CLICK : SRC_NONE;
   assign multi  = (req_click & req_result) | (req_click & req_melody) | (req_result & req_melody);
   assign accept = src_prio(win) > src_prio(src_q);
   assign tick   = tick_q == 10'(TICK_DIV - 1);
   assign len    = state_q == ST_GAP ? 11'(MEL_GAP_MS) : src_q == SRC_CLICK ? 11'(CLICK_MS) :
                   src_q == SRC_RESULT ? 11'(RESULT_MS) : 11'(MEL_NOTE_MS);
   assign expire = tick && ms_q == len - 11'd1;
   assign last   = src_q != SRC_MELODY || idx_q == 2'd3;
   // A new note (accept, preempt or gap end) holds the tone generator cleared for one edge.
   assign note_start = accept | (state_q == ST_GAP & expire);
   assign clear      = accept | expire | state_q == ST_IDLE;
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      idx_d   = idx_q;
      eq_d    = eq_q;
      done_d  = 1'b0;
      if (accept) begin
         state_d = ST_NOTE;
         src_d   = win;
         idx_d   = '0;
         eq_d    = win == SRC_RESULT ? result_equal : eq_q;
      end else if (expire && state_q == ST_GAP) begin
         state_d = ST_NOTE;
         idx_d   = idx_q + 2'd1;
      end else if (expire && state_q == ST_NOTE) begin
         state_d = last ? ST_IDLE : ST_GAP;
         src_d   = last ? SRC_NONE : src_q;
         done_d  = last;
      end
      tick_d = clear || tick ? '0 : tick_q + 10'd1;
      ms_d   = clear ? '0 : ms_q + {10'd0, tick};
      drop_d = multi | (win != SRC_NONE & ~accept);
   end
   always_ff @(posedge clk_1mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         src_q   <= SRC_NONE;
         idx_q   <= '0;
         eq_q    <= 1'b0;
         done_q  <= 1'b0;
         drop_q  <= 1'b0;
         tick_q  <= '0;
         ms_q    <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         idx_q   <= idx_d;
         eq_q    <= eq_d;
         done_q  <= done_d;
         drop_q  <= drop_d;
         tick_q  <= tick_d;
         ms_q    <= ms_d;
      end
   end
   piezo_tone_gen u_tone (
      .clk_1mhz   (clk_1mhz),
      .rst_n      (rst_n),
      .en         (state_d == ST_NOTE && !note_start),
      .half_period(note_hp(src_q, idx_q, eq_q)),
      .piezo      (piezo)
   );
   assign busy       = state_q != ST_IDLE;
   assign active_src = src_q;
   assign done       = done_q;
   assign req_drop   = drop_q;
endmodule
